// File: rtl/multiplicador_secuencial.sv
// Sequential shift-add multiplier (MUL/MULH/MULHSU/MULHU), one partial product per cycle.
// Define MULT_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier bits are zero.
module multiplicador_secuencial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is taken only in IDLE when done is low; busy is high from the
  // accepting edge until done rises; done is a one-cycle pulse and R holds until the next one.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e             state_q;
  logic [1:0]         op_q;
  logic               sign_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   r_q;

  logic               a_signed, b_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_step, prod_d, prod_fix;
  logic               last_step;
  logic [WIDTH-1:0]   result;

`ifdef MULT_EARLY_EXIT_EN
  logic [WIDTH-1:0]   mplier_q;
`endif

  always_comb begin
    a_signed = (op == 2'b01) || (op == 2'b10);
    b_signed = (op == 2'b01);
    // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
    mag_a = (a_signed && A[WIDTH-1]) ? -A : A;
    mag_b = (b_signed && B[WIDTH-1]) ? -B : B;

    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {sum, prod_q[WIDTH-1:1]};

`ifdef MULT_EARLY_EXIT_EN
    last_step = (mplier_q[WIDTH-1:1] == '0) || (cnt_q == LAST);
    // Skipped iterations would only shift, so apply their shifts in one go.
    prod_d    = last_step ? (prod_step >> (LAST - cnt_q)) : prod_step;
`else
    last_step = (cnt_q == LAST);
    prod_d    = prod_step;
`endif

    prod_fix = sign_q ? -prod_q : prod_q;
    result   = (op_q == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_q      <= '0;
`ifdef MULT_EARLY_EXIT_EN
      mplier_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !done_q) begin
            op_q     <= op;
            sign_q   <= (a_signed && A[WIDTH-1]) ^ (b_signed && B[WIDTH-1]);
            mcand_q  <= mag_a;
            prod_q   <= {{WIDTH{1'b0}}, mag_b};
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
`ifdef MULT_EARLY_EXIT_EN
            mplier_q <= mag_b;
`endif
          end
        end
        CALC: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + 1'b1;
`ifdef MULT_EARLY_EXIT_EN
          mplier_q <= mplier_q >> 1;
`endif
          if (last_step) state_q <= FIX;
        end
        FIX: begin
          r_q     <= result;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign R           = r_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Randomized bench for multiplicador_secuencial against a wide-arithmetic reference model.
module tb_multiplicador_secuencial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] r;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int exp_dones = 0;
  logic [31:0] exp_q[$];

  multiplicador_secuencial #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .R(r), .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [65:0] ex, ey, p;
    ex = (o == 2'b01 || o == 2'b10) ? {{34{x[31]}}, x} : {34'b0, x};
    ey = (o == 2'b01) ? {{34{y[31]}}, y} : {34'b0, y};
    p  = ex * ey;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycles from the accepting edge to the edge that raises done.
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] m;
    int hi;
    m  = (o == 2'b01 && y[31]) ? (~y + 32'd1) : y;
    hi = 0;
    for (int i = 0; i < 32; i++) if (m[i]) hi = i;
    return hi + 2;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge. mode 0: quiet, 1: random disturbance
  // during CALC, 2: restart with A=9 on cycle 5. If hold_start, start is raised in the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int mode, input bit hold_start);
    int n;
    logic [31:0] exp_r;
    int exp_l;
    exp_r = ref_mul(o, x, y);
    exp_l = ref_lat(o, y);
    exp_q.push_back(exp_r);
    exp_dones++;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < 100) begin
      if (mode == 1) begin
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        start = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        start = (n == 4);
        if (n == 4) a = 32'd9;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_eq("done_seen", done, 1);
    check_eq("latency", n, exp_l);
    check_eq("result", r, exp_q.pop_front());
    check_eq("busy_at_done", busy, 0);
    if (hold_start) begin
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; start = 1'b1;
    end
    @(negedge clk);
    check_eq("done_pulse_width", done, 0);
    check_eq("busy_ignored_start", busy, 0);
    check_eq("r_hold", r, exp_r);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_r", r, 0);
    check_eq("reset_state", dbg_state, 0);
    rst_n = 1'b1;

    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0, 0);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op(2'b00, 32'd5, 32'd1, 0, 0);
    do_op(2'b00, 32'd5, 32'h8000_0000, 0, 0);
    do_op(2'b00, 32'd3, 32'd4, 2, 0);
    do_op(2'b00, 32'd123, 32'd0, 0, 1);
    do_op(2'b11, 32'd1000, 32'd3000, 0, 0);

    // Abort mid-CALC, then start on the first edge after release.
    op = 2'b00; a = 32'h1234_5678; b = 32'hFFFF_0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_r", r, 0);
    check_eq("abort_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    for (int i = 0; i < 40; i++)
      do_op(2'($urandom_range(0, 3)), pick(), pick(), (i % 3 == 0) ? 1 : 0, (i % 5 == 0));

    repeat (3) @(negedge clk);
    check_eq("done_count", done_seen, exp_dones);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
